// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile bus master: width defaults, read-latency bound
// and the master FSM state encoding.
package regfile_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_MAX = 4;
  localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_TURN  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_bus_io.sv
// Physical side of the regfile port: tristate driver for the shared data bus and
// the register that captures read data for the response.
module regfile_bus_io #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              oe_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              cap_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] rdata_o,
  inout  wire  [DATA_W-1:0] rf_data_io
);

  logic [DATA_W-1:0] rdata_q;

  assign rf_data_io = oe_i ? wdata_i : 'z;

  // Cleared on every accept so a write response reports zero unless a verify read refills it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (cap_i) begin
      rdata_q <= rf_data_io;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/regfile_bus_master.sv
// Regfile bus master: converts valid/ready commands into WRITE / READ / TURN cycles.
// Optional build macro REGFILE_MASTER_WRVERIFY_EN adds a read-back compare after every write.
module regfile_bus_master
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we,
  output logic              rf_enable,
  inout  wire  [DATA_W-1:0] rf_data
);

  state_e                 state_q, state_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      rdata;
  logic                   accept;
  logic                   rd_last;
  logic                   bus_oe;
`ifdef REGFILE_MASTER_WRVERIFY_EN
  logic                   we_q;
`endif

  assign accept  = cmd_valid && cmd_ready;
  assign rd_last = (state_q == ST_READ) && (cnt_q == LAT_CNT_W'(RD_LAT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef REGFILE_MASTER_WRVERIFY_EN
      we_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
`ifdef REGFILE_MASTER_WRVERIFY_EN
        we_q    <= cmd_we;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = cmd_we ? ST_WRITE : ST_READ;
      end
      ST_WRITE: begin
`ifdef REGFILE_MASTER_WRVERIFY_EN
        state_d = ST_READ;
`else
        state_d = ST_RESP;
`endif
      end
      ST_READ: begin
        cnt_d = cnt_q + 1'b1;
        if (rd_last) state_d = ST_TURN;
      end
      ST_TURN: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every bus strobe decodes from the registered state, so rf_we and rf_enable cannot overlap.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE) && rst;
    rf_we     = (state_q == ST_WRITE);
    bus_oe    = (state_q == ST_WRITE);
    rf_enable = (state_q == ST_READ);
    rsp_valid = (state_q == ST_RESP);
  end

  assign rf_addr   = addr_q;
  assign rsp_rdata = rdata;

`ifdef REGFILE_MASTER_WRVERIFY_EN
  assign rsp_err = (state_q == ST_RESP) && we_q && (rdata != wdata_q);
`else
  assign rsp_err = 1'b0;
`endif

  regfile_bus_io #(
    .DATA_W (DATA_W)
  ) u_io (
    .clk        (clk),
    .rst        (rst),
    .oe_i       (bus_oe),
    .wdata_i    (wdata_q),
    .cap_i      (rd_last),
    .clr_i      (accept),
    .rdata_o    (rdata),
    .rf_data_io (rf_data)
  );

endmodule
